// File: rtl/event_capture.sv
`default_nettype none
// ============================================================================
// Module      : event_capture
// Description : Probe sampler and masked trigger that builds {ts, id, probe}
//               event words for the event FIFO, with one-shot/continuous FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module event_capture #(
    parameter int PROBE_W = 32,
    parameter int ID_W    = 8,
    parameter int TS_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PROBE_W-1:0]            probe,
    input  logic                          en,
    input  logic                          arm,
    input  logic [1:0]                    trig_mode,
    input  logic [PROBE_W-1:0]            trig_value,
    input  logic [PROBE_W-1:0]            trig_mask,
    input  logic                          clr_sticky,
    input  logic                          fifo_full,
    output logic                          evt_push,
    output logic [TS_W+ID_W+PROBE_W-1:0]  evt_wdata,
    output logic                          triggered_sticky,
    output logic                          fifo_overflow_sticky,
    output logic [1:0]                    state_o
);

    localparam int WORD_W = TS_W + ID_W + PROBE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ARMED = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PROBE_W-1:0]  probe_q, probe_d;
    logic [PROBE_W-1:0]  prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic                arm_q, arm_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                evt_push_q, evt_push_d;
    logic [WORD_W-1:0]   evt_wdata_q, evt_wdata_d;
    logic                trig_sticky_q, trig_sticky_d;
    logic                ovf_sticky_q, ovf_sticky_d;

    logic w_match_cur;
    logic w_match_prev;
    logic w_hit_raw;
    logic w_hit_qual;
    logic w_arm_rise;

    // Trigger evaluation on the registered sample pair (current, previous)
    always_comb begin
        w_match_cur  = ((probe_q ^ trig_value) & trig_mask) == '0;
        w_match_prev = ((prev_q  ^ trig_value) & trig_mask) == '0;
        w_hit_raw    = 1'b0;
        case (trig_mode)
            2'b00:   w_hit_raw = w_match_cur;
            2'b01:   w_hit_raw = prev_vld_q && (((probe_q ^ prev_q) & trig_mask) != '0);
            2'b10:   w_hit_raw = prev_vld_q && w_match_cur && !w_match_prev;
            2'b11:   w_hit_raw = prev_vld_q && ((probe_q & ~prev_q & trig_mask) != '0);
            default: w_hit_raw = 1'b0;
        endcase
        w_hit_qual = en && ((state_q == ST_RUN) || (state_q == ST_ARMED)) && w_hit_raw;
        w_arm_rise = arm && !arm_q;
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = arm ? ST_ARMED : ST_RUN;
                ST_RUN:   if (w_arm_rise) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (w_hit_qual)  state_d = ST_DONE;
                    else if (!arm)   state_d = ST_RUN;
                end
                ST_DONE: begin
                    if (w_arm_rise)  state_d = ST_ARMED;
                    else if (!arm)   state_d = ST_RUN;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Dropped hits still consume an id so that gaps expose FIFO overflow
    always_comb begin
        probe_d       = probe;
        prev_d        = probe_q;
        prev_vld_d    = (state_q != ST_IDLE);
        arm_d         = arm;
        ts_d          = (state_q == ST_IDLE) ? '0 : ts_q + TS_W'(1);
        id_d          = w_hit_qual ? id_q + ID_W'(1) : id_q;
        evt_push_d    = w_hit_qual && !fifo_full;
        evt_wdata_d   = evt_push_d ? {ts_q, id_q, probe_q} : evt_wdata_q;
        trig_sticky_d = trig_sticky_q;
        ovf_sticky_d  = ovf_sticky_q;
        if (clr_sticky) begin
            trig_sticky_d = 1'b0;
            ovf_sticky_d  = 1'b0;
        end
        if (w_hit_qual) begin
            trig_sticky_d = 1'b1;
        end
        if (w_hit_qual && fifo_full) begin
            ovf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            probe_q       <= '0;
            prev_q        <= '0;
            prev_vld_q    <= 1'b0;
            arm_q         <= 1'b0;
            ts_q          <= '0;
            id_q          <= '0;
            evt_push_q    <= 1'b0;
            evt_wdata_q   <= '0;
            trig_sticky_q <= 1'b0;
            ovf_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            probe_q       <= probe_d;
            prev_q        <= prev_d;
            prev_vld_q    <= prev_vld_d;
            arm_q         <= arm_d;
            ts_q          <= ts_d;
            id_q          <= id_d;
            evt_push_q    <= evt_push_d;
            evt_wdata_q   <= evt_wdata_d;
            trig_sticky_q <= trig_sticky_d;
            ovf_sticky_q  <= ovf_sticky_d;
        end
    end

    assign evt_push             = evt_push_q;
    assign evt_wdata            = evt_wdata_q;
    assign triggered_sticky     = trig_sticky_q;
    assign fifo_overflow_sticky = ovf_sticky_q;
    assign state_o              = state_q;

endmodule
`default_nettype wire
